// File: rtl/div_seq.sv
// div_seq: 32-bit sequential restoring divider with a valid/ready request and
// result handshake. It supports signed (DIV/REM) and unsigned (DIVU/REMU)
// division. A normal division takes one restoring step per cycle for 32 cycles,
// followed by one cycle that applies the signs. Divide-by-zero and signed
// overflow skip the iteration and return their fixed results after one cycle.
module div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state;
  logic [4:0]  step;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvsr;
  logic        neg_q;
  logic        neg_r;

  // Operand decode at the acceptance edge.
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        div_zero;
  logic        sgn_ovf;

  // One restoring step, and the final sign correction.
  logic [32:0] rem_sh;
  logic [33:0] trial;
  logic        no_borrow;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] q_fin;
  logic [31:0] r_fin;
  logic        unused_trial_bit;

  assign start_ready = (state == IDLE) && rst_n;
  assign busy        = (state != IDLE);

  // Decode the operand signs, the magnitudes and the special cases.
  always_comb begin
    a_neg    = is_signed & dividend[31];
    b_neg    = is_signed & divisor[31];
    a_mag    = a_neg ? (~dividend + 32'd1) : dividend;
    b_mag    = b_neg ? (~divisor + 32'd1) : divisor;
    div_zero = (divisor == '0);
    sgn_ovf  = is_signed && (dividend == 32'h8000_0000) && (divisor == '1);
  end

  // Restoring step: shift {rem,quo} left, then trial-subtract the divisor.
  // The partial remainder needs 33 bits after the shift when the divisor is
  // at least 2^31, so the subtraction is carried out in 34 bits and bit 33
  // gives the sign of the result.
  always_comb begin
    rem_sh           = {rem, quo[31]};
    trial            = {1'b0, rem_sh} + {2'b11, ~dvsr} + 34'd1;
    no_borrow        = ~trial[33];
    // A successful subtract always leaves a value below the divisor, so bit 32 is zero.
    unused_trial_bit = trial[32];
    rem_nxt          = no_borrow ? trial[31:0] : rem_sh[31:0];
    quo_nxt          = {quo[30:0], no_borrow};
    q_fin            = neg_q ? (~quo + 32'd1) : quo;
    r_fin            = neg_r ? (~rem + 32'd1) : rem;
  end

  // Control FSM and datapath registers. DONE uses its first cycle to present
  // the result, so both the special-case path and the iterative path deliver
  // the result one edge after they enter DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step      <= '0;
      rem       <= '0;
      quo       <= '0;
      dvsr      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            step <= '0;
            dvsr <= b_mag;
            if (div_zero) begin
              quo   <= '1;
              rem   <= dividend;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= DONE;
            end else if (sgn_ovf) begin
              quo   <= 32'h8000_0000;
              rem   <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= DONE;
            end else begin
              quo   <= a_mag;
              rem   <= '0;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem  <= rem_nxt;
          quo  <= quo_nxt;
          step <= step + 5'd1;
          if (step == 5'd31) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!out_valid) begin
            quotient  <= q_fin;
            remainder <= r_fin;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
